// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-bank dump engine: bank geometry
// constants (also used by the register bank) and the dump FSM state type.
package reg_dump_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/reg_dump.sv
// reg_dump: sequential read-out engine for the 16x16 GPR bank.
// On start it walks a contiguous (wrapping) address range on the bank's
// combinational read port and streams each word over valid/ready, flagging
// the final word and pulsing done when the dump completes.
// Optional build macro REG_DUMP_ADDR_TAG_EN adds o_dout_addr, the address
// each streamed word was read from.
module reg_dump
    import reg_dump_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_count,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_rb_addr,
    input  logic [DATA_W-1:0] i_rb_data,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_dout_last,
    output logic              o_done
`ifdef REG_DUMP_ADDR_TAG_EN
    ,
    output logic [ADDR_W-1:0] o_dout_addr
`endif
);

    // Requested counts above the bank size read the whole bank once.
    function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c);
        if (c > (ADDR_W+1)'(NUM_REGS)) begin
            return (ADDR_W+1)'(NUM_REGS);
        end
        return c;
    endfunction

    state_t              r_state;
    logic [ADDR_W:0]     r_rem;
    logic [ADDR_W-1:0]   r_rb_addr;
    logic [DATA_W-1:0]   r_dout;
    logic                r_valid;
    logic                r_last;
    logic                r_done;
    logic                r_busy;

    logic [ADDR_W:0]     w_count_sat;
    logic                w_load;
    logic                w_load_word;

    assign w_count_sat = sat_count(i_count);
    // The output slot can take a new word when empty or being drained.
    assign w_load      = !r_valid || i_dout_ready;
    assign w_load_word = (r_state == STREAM) && w_load && (r_rem != '0);

    // Dump FSM: owns the read address, remaining count and the output slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_rb_addr <= '0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_rb_addr <= i_base_addr;
                        r_rem     <= w_count_sat;
                        r_busy    <= 1'b1;
                        if (w_count_sat != '0) begin
                            r_state <= STREAM;
                        end else begin
                            // Nothing to read: finish straight away.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                STREAM: begin
                    if (w_load) begin
                        if (r_rem != '0) begin
                            // Capture the bank word as it stands at this edge;
                            // a write committing on the same edge is not seen.
                            r_dout    <= i_rb_data;
                            r_valid   <= 1'b1;
                            r_last    <= (r_rem == (ADDR_W+1)'(1));
                            r_rb_addr <= r_rb_addr + ADDR_W'(1);
                            r_rem     <= r_rem - (ADDR_W+1)'(1);
                        end else begin
                            // Final word has been accepted.
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_DUMP_ADDR_TAG_EN
    logic [ADDR_W-1:0] r_dout_addr;

    // Address tag travels with the word it was read from.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dout_addr <= '0;
        end else if (w_load_word) begin
            r_dout_addr <= r_rb_addr;
        end
    end

    assign o_dout_addr = r_dout_addr;
`else
    logic w_unused_load_word;
    assign w_unused_load_word = w_load_word;
`endif

    assign o_busy       = r_busy;
    assign o_rb_addr    = r_rb_addr;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_valid;
    assign o_dout_last  = r_last;
    assign o_done       = r_done;

endmodule

// File: tb/tb_reg_dump.sv
// Testbench for reg_dump: a behavioural bank + expected-word queue model,
// one per-cycle compare process, directed scenarios and randomized dumps.
`timescale 1ns/1ps
module tb_reg_dump;
    import reg_dump_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              l;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W:0]   cnt = '0;
    logic              ready = 1'b1;
    logic              busy;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] dout;
    logic              dv;
    logic              dl;
    logic              done;
`ifdef REG_DUMP_ADDR_TAG_EN
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] got_a[$];
`endif

    logic [DATA_W-1:0] bank [NUM_REGS];
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int rmode = 0;
    int start_edge = 0;
    int done_edge = -1;
    logic [DATA_W-1:0] got_w[$];
    ent_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    // Register bank model: synchronous write, combinational read.
    always @(posedge clk) if (wr_en) bank[wr_addr] <= wr_data;
    assign rb_data = bank[rb_addr];

    reg_dump dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_base_addr  (base),
        .i_count      (cnt),
        .o_busy       (busy),
        .o_rb_addr    (rb_addr),
        .i_rb_data    (rb_data),
        .o_dout       (dout),
        .o_dout_valid (dv),
        .i_dout_ready (ready),
        .o_dout_last  (dl),
        .o_done       (done)
`ifdef REG_DUMP_ADDR_TAG_EN
        ,
        .o_dout_addr  (daddr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready pattern: 0 = always ready, 1 = toggle, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ~ready;
                default: ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model state carried between compare cycles.
    logic              p_rst = 1'b1;
    logic              p_valid = 1'b0;
    logic              p_ready = 1'b0;
    logic              p_last = 1'b0;
    logic              p_accept = 1'b0;
    logic              p_zero = 1'b0;
    logic              p_edone = 1'b0;
    logic [ADDR_W-1:0] p_base = '0;
    logic              m_busy = 1'b0;
    logic [DATA_W-1:0] cur_d = '0;
    logic [ADDR_W-1:0] cur_a = '0;
    logic              cur_l = 1'b0;

    // Per-cycle comparison of DUT outputs against the queue model.
    initial begin : cmp
        ent_t e;
        logic held;
        logic ev;
        logic edn;
        int   n;
        forever begin
            @(negedge clk);
            if (p_rst) begin
                chk("rst_valid", 32'(dv), 32'(0));
                chk("rst_done", 32'(done), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_last", 32'(dl), 32'(0));
                chk("rst_dout", 32'(dout), 32'(0));
                chk("rst_rb_addr", 32'(rb_addr), 32'(0));
`ifdef REG_DUMP_ADDR_TAG_EN
                chk("rst_dout_addr", 32'(daddr), 32'(0));
`endif
                q.delete();
                m_busy  = 1'b0;
                p_edone = 1'b0;
                cur_l   = 1'b0;
            end else begin
                edn = p_zero || (p_valid && p_ready && p_last);
                if (p_edone) m_busy = 1'b0;
                if (p_accept) m_busy = 1'b1;
                chk("done", 32'(done), 32'(edn));
                chk("busy", 32'(busy), 32'(m_busy));
                if (edn) done_edge = ecnt;
                if (p_accept) begin
                    chk("rb_addr_start", 32'(rb_addr), 32'(p_base));
                    start_edge = ecnt;
                end
                held = p_valid && !p_ready;
                ev   = held || (q.size() > 0 && !p_accept);
                chk("valid", 32'(dv), 32'(ev));
                if (dv && ev) begin
                    if (!held) begin
                        e = q.pop_front();
                        cur_d = e.d;
                        cur_a = e.a;
                        cur_l = e.l;
                        got_w.push_back(dout);
`ifdef REG_DUMP_ADDR_TAG_EN
                        got_a.push_back(daddr);
`endif
                    end
                    chk(held ? "hold_dout" : "dout", 32'(dout), 32'(cur_d));
                    chk(held ? "hold_last" : "last", 32'(dl), 32'(cur_l));
`ifdef REG_DUMP_ADDR_TAG_EN
                    chk("dout_addr", 32'(daddr), 32'(cur_a));
`endif
                end
                if (edn) chk("words_left_at_done", 32'(q.size()), 32'(0));
                p_edone = edn;
            end
            // Record what the next edge will sample.
            p_rst    = rst;
            p_valid  = dv;
            p_ready  = ready;
            p_last   = dv && cur_l;
            p_accept = start && !m_busy && !rst;
            p_base   = base;
            n        = (int'(cnt) > NUM_REGS) ? NUM_REGS : int'(cnt);
            p_zero   = p_accept && (n == 0);
            if (p_accept) begin
                for (int k = 0; k < n; k++) begin
                    e.a = ADDR_W'(int'(base) + k);
                    e.d = bank[e.a];
                    e.l = (k == n - 1);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk);
        #1 wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("dump_timeout", 32'(t >= 400), 32'(0));
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        got_w.delete();
`ifdef REG_DUMP_ADDR_TAG_EN
        got_a.delete();
`endif
        done_edge = -1;
        @(posedge clk);
        #1 start = 1'b1; base = b; cnt = c;
        @(posedge clk);
        #1 start = 1'b0; base = ADDR_W'($urandom); cnt = (ADDR_W+1)'($urandom);
    endtask

    task automatic run_dump(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        pulse_start(b, c);
        wait_idle();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : drv
        int t;
        int n;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W:0]   rc;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) wr(ADDR_W'(i), DATA_W'(16'h1000 + i));

        // Full dump, ready held high.
        rmode = 0;
        run_dump(4'd0, 5'd16);
        chk("full_words", 32'(got_w.size()), 32'(16));
        chk("full_first", 32'(got_w[0]), 32'h1000);
        chk("full_final", 32'(got_w[15]), 32'h100F);
        chk("full_done_edge", 32'(done_edge - start_edge), 32'(17));

        // Wrap-around with toggling ready.
        rmode = 1;
        run_dump(4'd14, 5'd4);
        chk("wrap_words", 32'(got_w.size()), 32'(4));
        chk("wrap_w0", 32'(got_w[0]), 32'h100E);
        chk("wrap_w1", 32'(got_w[1]), 32'h100F);
        chk("wrap_w2", 32'(got_w[2]), 32'h1000);
        chk("wrap_w3", 32'(got_w[3]), 32'h1001);

        // Zero and clamped counts.
        rmode = 0;
        run_dump(4'd3, 5'd0);
        chk("zero_words", 32'(got_w.size()), 32'(0));
        chk("zero_done_edge", 32'(done_edge - start_edge), 32'(0));
        run_dump(4'd5, 5'd31);
        chk("clamp_words", 32'(got_w.size()), 32'(16));
        chk("clamp_first", 32'(got_w[0]), 32'h1005);
        chk("clamp_final", 32'(got_w[15]), 32'h1004);

        // Write to R5 on the very edge R5 is captured (edge 6).
        pulse_start(4'd0, 5'd8);
        repeat (5) @(posedge clk);
        #1 wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        @(posedge clk);
        #1 wr_en = 1'b0;
        wait_idle();
        chk("coherent_old", 32'(got_w[5]), 32'h1005);
        run_dump(4'd0, 5'd8);
        chk("coherent_new", 32'(got_w[5]), 32'hBEEF);

        // Reset in the middle of an 8-word dump.
        pulse_start(4'd0, 5'd8);
        t = 0;
        while (got_w.size() < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("rst_wait_timeout", 32'(t >= 100), 32'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_then_idle", 32'(busy), 32'(0));
        chk("rst_no_done", 32'(done_edge), 32'hFFFF_FFFF);

        // Start while busy must not restart the dump.
        pulse_start(4'd0, 5'd6);
        @(posedge clk);
        #1 start = 1'b1; base = 4'd9; cnt = 5'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("ign_words", 32'(got_w.size()), 32'(6));
        chk("ign_first", 32'(got_w[0]), 32'h1000);
        chk("ign_w5", 32'(got_w[5]), 32'hBEEF);

`ifdef REG_DUMP_ADDR_TAG_EN
        run_dump(4'd9, 5'd3);
        chk("tag_words", 32'(got_a.size()), 32'(3));
        chk("tag_a0", 32'(got_a[0]), 32'(9));
        chk("tag_a1", 32'(got_a[1]), 32'(10));
        chk("tag_a2", 32'(got_a[2]), 32'(11));
        chk("tag_d0", 32'(got_w[0]), 32'h1009);
`endif

        // Randomized dumps with random bank contents and random ready.
        for (int it = 0; it < 20; it++) begin
            rmode = 2;
            for (int i = 0; i < NUM_REGS; i++) wr(ADDR_W'(i), DATA_W'($urandom));
            rb = ADDR_W'($urandom);
            rc = (ADDR_W+1)'($urandom_range(0, 31));
            n  = (int'(rc) > NUM_REGS) ? NUM_REGS : int'(rc);
            run_dump(rb, rc);
            chk("rand_words", 32'(got_w.size()), 32'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential read-out engine for the 16×16 general-purpose register bank. On a start pulse it walks a contiguous address range on the bank's combinational read port and streams each word out over a valid/ready handshake at up to one word per cycle, marking the final word. It sits beside the bank's write port and serves debug dump, image-result unload and checkpoint paths without stalling GPR writes.

## Interface
- DATA_W, 16, register width; matches the bank data width.
- ADDR_W, 4, register address width; the bank holds 2^ADDR_W registers.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a dump; sampled only in IDLE.
- base_addr  input  ADDR_W  first register address; sampled with start.
- count  input  ADDR_W+1  number of registers to read, 0..16; values above 16 clamp to 16.
- busy  output  1  high in any state other than IDLE.
- rb_addr  output  ADDR_W  drives the bank's read address.
- rb_data  input  DATA_W  bank read data, combinational from rb_addr.
- dout  output  DATA_W  streamed register word.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  consumer accepts the word.
- dout_last  output  1  qualifies the final word of the dump.
- done  output  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: if start=1, latch rb_addr←base_addr and remaining←min(count,16). Go to STREAM if the clamped count is nonzero, otherwise go to DONE.
- STREAM: define load = !dout_valid || dout_ready.
  - load && remaining≠0: dout←rb_data, dout_valid←1, dout_last←(remaining==1), rb_addr←rb_addr+1 (mod 16), remaining←remaining−1.
  - load && remaining==0: dout_valid←0, dout_last←0, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Handshake: once dout_valid is high, dout and dout_last stay stable until accepted (dout_valid && dout_ready at a rising edge). dout_valid never drops without acceptance.
- Address wrap: base_addr=14 with count=4 reads 14, 15, 0, 1.
- start while busy is ignored. base_addr and count are don't-care outside an accepted start.
- Coherence: each word is the bank contents at its capture edge. A bank write committing on that same edge is not visible; the old value is captured.
- Reset (rst=1), including mid-dump: state←IDLE; dout, dout_valid, dout_last, done, busy, rb_addr and remaining all ←0. Any pending word is discarded and no done pulse is produced.

## Timing
- start sampled at edge 0. rb_addr=base_addr after edge 0. The first word is valid after edge 1.
- With dout_ready held high, one word is transferred per cycle. For N words, word i is loaded at edge i+1 and accepted at edge i+2.
- The last word is accepted at edge N+1. dout_valid falls and done rises after edge N+1; done falls and busy falls after edge N+2.
- count=0: done is high after edge 0 and busy is low after edge 1. No word is produced.
- Backpressure adds exactly one cycle per low-ready cycle. No bubbles are inserted while ready is high.

## Configuration
- REG_DUMP_ADDR_TAG_EN defined: adds output dout_addr [ADDR_W-1:0]. It holds the address dout was read from, is loaded together with dout, and resets to 0.
- REG_DUMP_ADDR_TAG_EN undefined: the dout_addr port and its register are absent. All other behaviour is identical.

## Structure
- Shared package reg_dump_pkg contains:
  - the state enum (IDLE, STREAM, DONE);
  - DATA_W=16, ADDR_W=4, NUM_REGS=16 constants, shared with the register bank.
- Single module; no sub-module.

## Test plan
- Full dump: preload R[i]=16'h1000+i, base=0, count=16, ready=1 → 16 words 1000..100F on consecutive cycles, last on 100F, done after edge 17.
- Wrap and backpressure: base=14, count=4, ready toggling 1,0 → words R14, R15, R0, R1 in order. Each word is held stable while ready=0 and no word is duplicated.
- Zero and clamped counts:
  - count=0 → no dout_valid, done one cycle after start.
  - count=31 → exactly 16 words.
- Concurrent write: during a dump, write R5=16'hBEEF on the same edge that R5 is captured → the old value is streamed; on a rerun, BEEF appears.
- Reset and ignored start: assert rst after word 2 of 8 → all outputs 0 next cycle, no done. A start pulsed while busy causes no restart.
- With REG_DUMP_ADDR_TAG_EN: base=9, count=3 → dout_addr 9, 10, 11, aligned with the corresponding words.
